// File: rtl/rotation_tracker.sv
// rotation_tracker: classifies the rotator's one-hot code stream into
// clockwise / counter-clockwise steps, counts full turns per direction and
// keeps a sticky error status for illegal codes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no reference code yet; waiting for the first legal code
// S_TRACK | reference held in r_prev; each legal code is a step or hold
// S_FAULT | illegal code seen; samples ignored until reset or clear
module rotation_tracker #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [2:0]       z_in,
  input  logic             z_valid,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             turn_pulse,
  output logic [CNT_W-1:0] cw_turns,
  output logic [CNT_W-1:0] ccw_turns,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             tracking
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [1:0]       r_prev;
  logic [1:0]       r_cw_ph;
  logic [1:0]       r_ccw_ph;
  logic             r_step_cw;
  logic             r_step_ccw;
  logic             r_turn;
  logic [CNT_W-1:0] r_cw_turns;
  logic [CNT_W-1:0] r_ccw_turns;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;
  logic             r_tracking;

  logic       w_legal;
  logic       w_idle;
  logic [1:0] w_idx;
  logic [1:0] w_prev_inc;
  logic       w_is_cw;
  logic       w_is_ccw;

  // Decode the incoming code and classify it against the stored reference.
  always_comb begin
    w_legal = 1'b0;
    w_idle  = 1'b0;
    w_idx   = 2'd0;
    case (z_in)
      3'b110:  begin w_legal = 1'b1; w_idx = 2'd0; end
      3'b111:  begin w_legal = 1'b1; w_idx = 2'd1; end
      3'b101:  begin w_legal = 1'b1; w_idx = 2'd2; end
      3'b000:  w_idle = 1'b1;
      default: ;
    endcase
    w_prev_inc = (r_prev == 2'd2) ? 2'd0 : r_prev + 2'd1;
    w_is_cw    = w_legal && (w_idx == w_prev_inc);
    w_is_ccw   = w_legal && (w_idx != r_prev) && !w_is_cw;
  end

  // FSM, phase tracking, saturating counters and one-cycle pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 2'd0;
      r_cw_ph     <= 2'd0;
      r_ccw_ph    <= 2'd0;
      r_step_cw   <= 1'b0;
      r_step_ccw  <= 1'b0;
      r_turn      <= 1'b0;
      r_cw_turns  <= '0;
      r_ccw_turns <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_tracking  <= 1'b0;
    end else begin
      r_step_cw  <= 1'b0;
      r_step_ccw <= 1'b0;
      r_turn     <= 1'b0;
      if (clear) begin
        r_state     <= S_IDLE;
        r_prev      <= 2'd0;
        r_cw_ph     <= 2'd0;
        r_ccw_ph    <= 2'd0;
        r_cw_turns  <= '0;
        r_ccw_turns <= '0;
        r_err       <= 1'b0;
        r_err_count <= '0;
        r_tracking  <= 1'b0;
      end else if (z_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_legal) begin
              r_prev     <= w_idx;
              r_state    <= S_TRACK;
              r_tracking <= 1'b1;
            end else if (!w_idle) begin
              r_state <= S_FAULT;
              r_err   <= 1'b1;
              if (r_err_count != C_MAX) r_err_count <= r_err_count + CNT_W'(1);
            end
          end
          S_TRACK: begin
            if (w_legal) begin
              r_prev <= w_idx;
              if (w_is_cw) begin
                r_step_cw <= 1'b1;
                r_ccw_ph  <= 2'd0;
                if (r_cw_ph == 2'd2) begin
                  r_cw_ph <= 2'd0;
                  r_turn  <= 1'b1;
                  if (r_cw_turns != C_MAX) r_cw_turns <= r_cw_turns + CNT_W'(1);
                end else begin
                  r_cw_ph <= r_cw_ph + 2'd1;
                end
              end else if (w_is_ccw) begin
                r_step_ccw <= 1'b1;
                r_cw_ph    <= 2'd0;
                if (r_ccw_ph == 2'd2) begin
                  r_ccw_ph <= 2'd0;
                  r_turn   <= 1'b1;
                  if (r_ccw_turns != C_MAX) r_ccw_turns <= r_ccw_turns + CNT_W'(1);
                end else begin
                  r_ccw_ph <= r_ccw_ph + 2'd1;
                end
              end
            end else if (w_idle) begin
              r_state    <= S_IDLE;
              r_tracking <= 1'b0;
              r_cw_ph    <= 2'd0;
              r_ccw_ph   <= 2'd0;
            end else begin
              r_state    <= S_FAULT;
              r_tracking <= 1'b0;
              r_err      <= 1'b1;
              if (r_err_count != C_MAX) r_err_count <= r_err_count + CNT_W'(1);
            end
          end
          S_FAULT: ;
          default: begin
            r_state    <= S_IDLE;
            r_tracking <= 1'b0;
          end
        endcase
      end
    end
  end

  assign step_cw    = r_step_cw;
  assign step_ccw   = r_step_ccw;
  assign turn_pulse = r_turn;
  assign cw_turns   = r_cw_turns;
  assign ccw_turns  = r_ccw_turns;
  assign err        = r_err;
  assign err_count  = r_err_count;
  assign tracking   = r_tracking;

endmodule

// File: tb/tb_rotation_tracker.sv
// Bench for rotation_tracker: two instances (default width and CNT_W=2)
// share one stimulus stream and are compared against a run-length model.
module tb_rotation_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [2:0] z_in;
  logic       z_valid;

  logic       a_cw, a_ccw, a_tp, a_err, a_trk;
  logic [7:0] a_cwt, a_ccwt, a_errc;
  logic       b_cw, b_ccw, b_tp, b_err, b_trk;
  logic [1:0] b_cwt, b_ccwt, b_errc;

  int errors = 0;
  int checks = 0;

  // model: mode 0 idle, 1 track, 2 fault; runs = consecutive same-direction steps
  int m_mode, m_prev, m_cw_run, m_ccw_run;
  int m_cwt, m_ccwt, m_err, m_errc;
  int m_pcw, m_pccw, m_ptp;

  rotation_tracker u_a (
    .clock(clock), .reset(reset), .clear(clear), .z_in(z_in), .z_valid(z_valid),
    .step_cw(a_cw), .step_ccw(a_ccw), .turn_pulse(a_tp), .cw_turns(a_cwt),
    .ccw_turns(a_ccwt), .err(a_err), .err_count(a_errc), .tracking(a_trk)
  );

  rotation_tracker #(.CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .clear(clear), .z_in(z_in), .z_valid(z_valid),
    .step_cw(b_cw), .step_ccw(b_ccw), .turn_pulse(b_tp), .cw_turns(b_cwt),
    .ccw_turns(b_ccwt), .err(b_err), .err_count(b_errc), .tracking(b_trk)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int code_idx(input logic [2:0] z);
    case (z)
      3'b110:  return 0;
      3'b111:  return 1;
      3'b101:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_cw_run = 0; m_ccw_run = 0;
    m_cwt = 0; m_ccwt = 0; m_err = 0; m_errc = 0;
    m_pcw = 0; m_pccw = 0; m_ptp = 0;
  endtask

  task automatic model_step(input logic [2:0] z, input logic v, input logic clr);
    int idx, d;
    m_pcw = 0; m_pccw = 0; m_ptp = 0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      idx = code_idx(z);
      if (m_mode == 0) begin
        if (idx >= 0) begin
          m_prev = idx; m_mode = 1;
        end else if (z != 3'b000) begin
          m_mode = 2; m_err = 1; m_errc++;
        end
      end else if (m_mode == 1) begin
        if (idx >= 0) begin
          d = (idx - m_prev + 3) % 3;
          if (d == 1) begin
            m_pcw = 1; m_ccw_run = 0; m_cw_run++;
            if (m_cw_run % 3 == 0) begin m_cwt++; m_ptp = 1; end
          end else if (d == 2) begin
            m_pccw = 1; m_cw_run = 0; m_ccw_run++;
            if (m_ccw_run % 3 == 0) begin m_ccwt++; m_ptp = 1; end
          end
          m_prev = idx;
        end else if (z == 3'b000) begin
          m_mode = 0; m_cw_run = 0; m_ccw_run = 0;
        end else begin
          m_mode = 2; m_err = 1; m_errc++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a.step_cw"},    int'(a_cw),   m_pcw);
    chk({tag, ".a.step_ccw"},   int'(a_ccw),  m_pccw);
    chk({tag, ".a.turn_pulse"}, int'(a_tp),   m_ptp);
    chk({tag, ".a.cw_turns"},   int'(a_cwt),  sat(m_cwt, 8));
    chk({tag, ".a.ccw_turns"},  int'(a_ccwt), sat(m_ccwt, 8));
    chk({tag, ".a.err"},        int'(a_err),  m_err);
    chk({tag, ".a.err_count"},  int'(a_errc), sat(m_errc, 8));
    chk({tag, ".a.tracking"},   int'(a_trk),  (m_mode == 1) ? 1 : 0);
    chk({tag, ".b.step_cw"},    int'(b_cw),   m_pcw);
    chk({tag, ".b.step_ccw"},   int'(b_ccw),  m_pccw);
    chk({tag, ".b.turn_pulse"}, int'(b_tp),   m_ptp);
    chk({tag, ".b.cw_turns"},   int'(b_cwt),  sat(m_cwt, 2));
    chk({tag, ".b.ccw_turns"},  int'(b_ccwt), sat(m_ccwt, 2));
    chk({tag, ".b.err"},        int'(b_err),  m_err);
    chk({tag, ".b.err_count"},  int'(b_errc), sat(m_errc, 2));
    chk({tag, ".b.tracking"},   int'(b_trk),  (m_mode == 1) ? 1 : 0);
  endtask

  task automatic sample(input string tag, input logic [2:0] z, input logic v, input logic clr);
    @(negedge clock);
    z_in = z; z_valid = v; clear = clr;
    model_step(z, v, clr);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic areset(input string tag);
    @(negedge clock);
    reset = 1'b1; z_valid = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clock);
    #1;
    check_all({tag, ".held"});
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [2:0] illegal_codes [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

  initial begin
    int r;
    logic [2:0] z;
    logic v, c;

    reset = 1'b1; clear = 1'b0; z_in = 3'b000; z_valid = 1'b0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clock);
    reset = 1'b0;

    // clockwise stream: turns on samples 4 and 7
    sample("cw1", 3'b110, 1, 0);
    sample("cw2", 3'b111, 1, 0);
    sample("cw3", 3'b101, 1, 0);
    sample("cw4", 3'b110, 1, 0);
    chk("cw4.turn", int'(a_tp), 1);
    sample("cw5", 3'b111, 1, 0);
    sample("cw6", 3'b101, 1, 0);
    sample("cw7", 3'b110, 1, 0);
    chk("cw7.cw_turns", int'(a_cwt), 2);

    // counter-clockwise, then a reversal
    areset("r1");
    sample("ccw1", 3'b111, 1, 0);
    sample("ccw2", 3'b110, 1, 0);
    sample("ccw3", 3'b101, 1, 0);
    sample("ccw4", 3'b111, 1, 0);
    chk("ccw4.ccw_turns", int'(a_ccwt), 1);
    sample("ccw5", 3'b110, 1, 0);
    sample("rev1", 3'b111, 1, 0);
    chk("rev1.cw_turns", int'(a_cwt), 0);

    // hold and gaps
    sample("clr1", 3'b000, 0, 1);
    sample("hold1", 3'b110, 1, 0);
    sample("hold2", 3'b110, 1, 0);
    for (int i = 0; i < 3; i++) sample("gap", 3'b111, 0, 0);
    sample("hold3", 3'b111, 1, 0);

    // illegal code, frozen fault, clear with a discarded sample
    sample("clr2", 3'b000, 0, 1);
    sample("ill1", 3'b110, 1, 0);
    sample("ill2", 3'b011, 1, 0);
    sample("ill3", 3'b111, 1, 0);
    sample("ill4", 3'b101, 1, 0);
    sample("illclr", 3'b110, 1, 1);
    sample("illpost", 3'b111, 1, 0);

    // idle code returns to IDLE and discards the phase
    sample("id1", 3'b101, 1, 0);
    sample("id2", 3'b110, 1, 0);
    sample("id3", 3'b000, 1, 0);
    sample("id4", 3'b110, 1, 0);
    sample("id5", 3'b111, 1, 0);

    // async reset mid-turn
    sample("clr3", 3'b000, 0, 1);
    sample("ar1", 3'b110, 1, 0);
    sample("ar2", 3'b111, 1, 0);
    areset("ar");
    sample("ar3", 3'b101, 1, 0);

    // saturation on the narrow instance: 4 clockwise turns
    areset("r2");
    sample("sat0", 3'b110, 1, 0);
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: z = 3'b111;
        1: z = 3'b101;
        default: z = 3'b110;
      endcase
      sample("sat", z, 1, 0);
    end
    chk("sat.b.cw_turns", int'(b_cwt), 3);

    // randomized stream
    areset("r3");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      z = 3'b110;
      else if (r < 60) z = 3'b111;
      else if (r < 90) z = 3'b101;
      else if (r < 95) z = 3'b000;
      else             z = illegal_codes[$urandom_range(0, 3)];
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 24) == 0);
      sample("rnd", z, v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotation_tracker.md
# rotation_tracker

Downstream consumer of the 3-bit one-hot Mealy rotation FSM's output code stream (`z_out`). It classifies each new code against the previous one as a clockwise step, a counter-clockwise step, a hold, or an illegal code. It keeps per-direction full-turn counters and a sticky error status. The host samples these to confirm the rotator's direction and health.

## Interface
Parameters:
- `CNT_W`, default 8: width of the turn counters and the error counter. All three saturate at 2^CNT_W-1.

Ports (clock and reset first):
- `clock`  input  1: single clock. All state updates on posedge.
- `reset`  input  1: asynchronous, active-high. Forces every register to its reset value immediately.
- `clear`  input  1: synchronous clear. Same effect as reset, but applied at posedge.
- `z_in`  input  3: code from the rotator FSM (its `z_out`).
- `z_valid`  input  1: when high, `z_in` is sampled at this posedge.
- `step_cw`  output  1: one-cycle pulse for a clockwise step.
- `step_ccw`  output  1: one-cycle pulse for a counter-clockwise step.
- `turn_pulse`  output  1: one-cycle pulse when either turn counter increments.
- `cw_turns`  output  CNT_W: completed clockwise turns.
- `ccw_turns`  output  CNT_W: completed counter-clockwise turns.
- `err`  output  1: sticky error flag.
- `err_count`  output  CNT_W: number of illegal codes accepted.
- `tracking`  output  1: high while the FSM is in TRACK.

## Operation
- **Code map:** 3'b110 is index 0, 3'b111 is index 1, 3'b101 is index 2.
  - 3'b000 is the idle code.
  - 3'b001, 3'b010, 3'b011 and 3'b100 are illegal.
- **FSM states:** IDLE, TRACK, FAULT.
  - IDLE is the reset state.
  - `tracking` = (state == TRACK).
- **IDLE**, on a valid sample:
  - Legal code: store `prev_idx`, go to TRACK. No step pulse.
  - Idle code: stay in IDLE.
  - Illegal code: go to FAULT.
- **TRACK**, on a valid sample, compute d = (idx − prev_idx) mod 3:
  - d = 0 (hold): no pulse.
  - d = 1: clockwise step.
  - d = 2: counter-clockwise step.
  - On any legal code, `prev_idx` takes the new index.
  - Idle code: go to IDLE. Both phases reset to 0. Counters are kept.
  - Illegal code: go to FAULT.
- **Phases:** two 2-bit phase registers, `cw_ph` and `ccw_ph`, each counting 0..2.
  - Clockwise step: `ccw_ph` is set to 0. `cw_ph` is incremented. When it wraps from 2 to 0, `cw_turns` increments (saturating) and `turn_pulse` fires.
  - Counter-clockwise step: the mirror image on `ccw_ph` and `ccw_turns`.
- **FAULT:**
  - On entry: set `err`, increment `err_count` (saturating).
  - While in FAULT: ignore all further samples, no pulses, counters frozen.
  - Exit only via `reset` or `clear`, both of which go to IDLE.
- **Priority:** `reset` > `clear` > `z_valid`.
  - `clear` with `z_valid` asserted in the same cycle: the sample is discarded.
- **Hold:** when `z_valid` is low, nothing changes and all pulses are 0.
- **Reset values:**
  - All outputs are 0.
  - `prev_idx`, `cw_ph` and `ccw_ph` are 0.
  - State is IDLE.
- **Mid-stream reset:** reset or clear applied in the middle of a turn discards any partial phase. Counting restarts from IDLE.

## Timing
- **Latency:** a `z_in` sampled at posedge N produces its `step_*` and `turn_pulse` outputs, and the updated counters and `err`, all valid after posedge N and for exactly that one cycle (pulses) or until the next change (counters).
- **Registered outputs:** all outputs come straight from registers. There is no combinational path from `z_in` to any output.
- **Throughput:** back-to-back samples every cycle are supported. Each sample is classified against the immediately preceding accepted legal sample.
- **Reset:** `reset` is asynchronous. Outputs clear within the same timestep without waiting for a clock edge.
- **Pulse exclusivity:** at most one of `step_cw` and `step_ccw` is high in any cycle. When `turn_pulse` is high, exactly one of them is high.

## Test plan
- **Clockwise stream:** after reset, apply `z_valid`=1 with 110,111,101,110,111,101,110.
  - `step_cw` pulses 6 times.
  - `turn_pulse` fires on the 4th and 7th samples.
  - Result: `cw_turns`=2, `ccw_turns`=0, `err`=0.
- **Counter-clockwise stream:** 111,110,101,111 gives 3 `step_ccw` pulses and `ccw_turns`=1. Follow with 110 and 111: one `step_ccw` then one `step_cw`. `cw_turns` stays 0, because the reversal resets `ccw_ph` and the single clockwise step leaves `cw_ph`=1.
- **Hold and gaps:** 110,110, then `z_valid`=0 for 3 cycles, then 111.
  - Exactly one `step_cw`, on the final sample.
  - No pulses during the hold or the gap.
- **Illegal code:** 110, then 011.
  - `err`=1, `err_count`=1, `tracking`=0.
  - Further 111/101 samples produce no pulses.
  - `clear` returns all outputs to 0 and the FSM to IDLE.
- **Async reset mid-turn:** 110,111, then assert `reset` between edges.
  - All outputs read 0 before the next posedge.
  - After release, 101 only enters TRACK (no pulse).
- **Saturation:** with `CNT_W`=2, run 4 clockwise turns. `cw_turns` holds at 3. `turn_pulse` still fires on each wrap.
